// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
package shift_seq_ctrl_pkg;

    // Same 2-bit encoding as the existing 4-bit shift stage.
    typedef enum logic [1:0] {
        OpRol = 2'b00,
        OpSll = 2'b01,
        OpSra = 2'b10,
        OpSrl = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } seq_state_t;

endpackage

// File: rtl/shift_amt_stage.sv
// Combinational power-of-two shift stage. amt is one-hot: bit k selects a
// shift by 2^k. An all-zero amt passes the operand through unchanged.
module shift_amt_stage
    import shift_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] amt,
    output logic [WIDTH-1:0] out
);

    // Apply the selected power-of-two shift for the requested operation.
    always_comb begin
        out = in;
        for (int i = 0; i < int'(CNT_W); i++) begin
            if (amt[i]) begin
                unique case (shift_op_t'(op))
                    OpRol: out = (in << (1 << i)) | (in >> (int'(WIDTH) - (1 << i)));
                    OpSll: out = in << (1 << i);
                    OpSra: out = WIDTH'($signed(in) >>> (1 << i));
                    OpSrl: out = in >> (1 << i);
                    default: out = in;
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: walks the shift amount MSB first, one bit per
// cycle, through a single shared shift stage. Start/Done handshake.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [CNT_W-1:0] cnt,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned KW = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam logic [KW-1:0] KMax = KW'(CNT_W - 1);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] stage_out;
    logic [CNT_W-1:0] stage_amt;
    logic             accept;
    logic             k_last;

    // A new request is taken in IDLE or DONE; Start during SHIFT is dropped.
    assign accept    = start && (state_q != StShift);
    assign k_last    = (k_q == '0);
    assign stage_amt = CNT_W'(1) << k_q;

    shift_amt_stage #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_stage (
        .in  (acc_q),
        .op  (op_q),
        .amt (stage_amt),
        .out (stage_out)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (k_last) state_d = StDone;
            StDone:  state_d = start ? StShift : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode.
    always_comb begin
        busy = (state_q == StShift);
        done = (state_q == StDone);
    end

    // Datapath next-state: capture, per-bit shift, and result load on DONE entry.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        op_d  = op_q;
        k_d   = k_q;
        out_d = out;
        if (accept) begin
            acc_d = in;
            cnt_d = cnt;
            op_d  = op;
            k_d   = KMax;
        end else if (state_q == StShift) begin
            if (cnt_q[k_q]) begin
                acc_d = stage_out;
            end
            if (k_last) begin
                // Out takes the final stage result so it is valid in the DONE cycle.
                out_d = acc_d;
            end else begin
                k_d = k_q - KW'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            op_q  <= '0;
            k_q   <= '0;
            out   <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            op_q  <= op_d;
            k_q   <= k_d;
            out   <= out_d;
        end
    end

endmodule
